// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, the protected-register lookup and the reset-value rule for the register file.
package regfile_pkg;
  localparam int DEF_DW = 32;
  localparam int DEF_NREG = 16;
  localparam int DEF_NRD = 2;
  localparam logic [15:0] DEF_PROT_MASK = 16'hC000;
  // When set, each register resets to its own index; when clear, it resets to zero.
  localparam bit RST_TO_INDEX = 1'b1;
  function automatic logic is_prot(input logic [63:0] mask, input logic [5:0] addr);
    return mask[addr];
  endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy flops; a new issue beats a same-edge completing write.
module rf_scoreboard import regfile_pkg::*; #(
  parameter int NREG = DEF_NREG,
  parameter int NRD = DEF_NRD,
  parameter logic [NREG-1:0] PROT_MASK = NREG'(DEF_PROT_MASK),
  localparam int AW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        clr_en,
  input  logic [2*AW-1:0]   clr_addr,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  input  logic [NRD*AW-1:0] rd_addr,
  input  logic [NRD-1:0]    hit,
  output logic [NRD-1:0]    rd_busy
);
  logic [NREG-1:0] busy_q, busy_d;
  logic iss_ok;
  assign iss_ok = iss_en && !is_prot(64'(PROT_MASK), 6'(iss_addr));
  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < NREG; k++)
      busy_d[k] = (iss_ok && iss_addr == AW'(k)) ||
                  (busy_q[k] && !(clr_en[0] && clr_addr[0 +: AW] == AW'(k))
                             && !(clr_en[1] && clr_addr[AW +: AW] == AW'(k)));
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else busy_q <= busy_d;
  end
  for (genvar i = 0; i < NRD; i++) begin : g_busy
    assign rd_busy[i] = busy_q[rd_addr[i*AW +: AW]] & ~hit[i];
  end
endmodule

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file with two write ports, optional write-to-read bypass,
// busy scoreboard for decode hazards, write-protected registers and a registered debug port.
module regfile_mp_sb import regfile_pkg::*; #(
  parameter int DW = DEF_DW,
  parameter int NREG = DEF_NREG,
  parameter int NRD = DEF_NRD,
  parameter logic [NREG-1:0] PROT_MASK = NREG'(DEF_PROT_MASK),
  parameter bit BYPASS = 1'b1,
  localparam int AW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic [1:0]        wr_en,
  input  logic [2*AW-1:0]   wr_addr,
  input  logic [2*DW-1:0]   wr_data,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DW-1:0]     dbg_data,
  output logic              wr_err
);
  logic [DW-1:0] rf_q [NREG];
  logic [DW-1:0] rf_d [NREG];
  logic [DW-1:0] dbg_q;
  logic err_q;
  logic [1:0] we;
  logic [NRD-1:0] hit;
  // Writes are suppressed while reset is high so bypass cannot leak discarded data.
  always_comb begin
    we = '0;
    for (int p = 0; p < 2; p++)
      we[p] = wr_en[p] && !reset && !is_prot(64'(PROT_MASK), 6'(wr_addr[p*AW +: AW]));
  end
  always_comb begin
    for (int k = 0; k < NREG; k++)
      rf_d[k] = (we[1] && wr_addr[AW +: AW] == AW'(k)) ? wr_data[DW +: DW] :
                (we[0] && wr_addr[0 +: AW] == AW'(k))  ? wr_data[0 +: DW]  : rf_q[k];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NREG; k++) rf_q[k] <= RST_TO_INDEX ? DW'(k) : '0;
      dbg_q <= '0;
      err_q <= 1'b0;
    end else begin
      rf_q <= rf_d;
      dbg_q <= rf_d[dbg_addr];
      err_q <= |(wr_en & ~we);
    end
  end
  assign dbg_data = dbg_q;
  assign wr_err = err_q;
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic h0, h1;
    assign ra = rd_addr[i*AW +: AW];
    assign h1 = BYPASS && we[1] && wr_addr[AW +: AW] == ra;
    assign h0 = BYPASS && we[0] && wr_addr[0 +: AW] == ra;
    assign hit[i] = h0 | h1;
    assign rd_data[i*DW +: DW] = h1 ? wr_data[DW +: DW] : h0 ? wr_data[0 +: DW] : rf_q[ra];
  end
  rf_scoreboard #(.NREG(NREG), .NRD(NRD), .PROT_MASK(PROT_MASK)) u_sb (
    .clk(clk), .reset(reset), .clr_en(we), .clr_addr(wr_addr),
    .iss_en(iss_en), .iss_addr(iss_addr), .rd_addr(rd_addr), .hit(hit), .rd_busy(rd_busy)
  );
endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: directed and random stimulus on bypassing and non-bypassing instances, checked by a scoreboard.
module tb_regfile_mp_sb;
  logic clk = 0, reset = 1;
  logic [7:0] rd_addr = '0, wr_addr = '0;
  logic [1:0] wr_en = '0;
  logic [63:0] wr_data = '0;
  logic iss_en = 0;
  logic [3:0] iss_addr = '0, dbg_addr = '0;
  logic [63:0] rd_data_b, rd_data_n;
  logic [1:0] rd_busy_b, rd_busy_n;
  logic [31:0] dbg_b, dbg_n;
  logic err_b, err_n;

  regfile_mp_sb #(.BYPASS(1)) u_b (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .dbg_addr(dbg_addr), .dbg_data(dbg_b), .wr_err(err_b));
  regfile_mp_sb #(.BYPASS(0)) u_n (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .dbg_addr(dbg_addr), .dbg_data(dbg_n), .wr_err(err_n));

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] bd, nd;
    logic [1:0] bb, nb;
    logic [31:0] dbg;
    logic err;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;

  logic [31:0] mem [16];
  bit busy [16];
  logic [31:0] m_dbg;
  bit m_err;

  function automatic bit prot(input logic [3:0] a);
    return a >= 4'd14;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 16; k++) begin
      mem[k] = k;
      busy[k] = 0;
    end
    m_dbg = '0;
    m_err = 0;
  endfunction

  function automatic bit eff(input int p);
    return wr_en[p] && !reset && !prot(wr_addr[p*4 +: 4]);
  endfunction

  function automatic void push_exp();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      logic [3:0] ra = rd_addr[i*4 +: 4];
      bit h1 = eff(1) && wr_addr[7:4] == ra;
      bit h0 = eff(0) && wr_addr[3:0] == ra;
      e.bd[i*32 +: 32] = h1 ? wr_data[63:32] : h0 ? wr_data[31:0] : mem[ra];
      e.nd[i*32 +: 32] = mem[ra];
      e.bb[i] = busy[ra] && !(h0 || h1);
      e.nb[i] = busy[ra];
    end
    e.dbg = m_dbg;
    e.err = m_err;
    q.push_back(e);
  endfunction

  function automatic void commit();
    if (reset) return;
    m_err = (wr_en[0] && prot(wr_addr[3:0])) || (wr_en[1] && prot(wr_addr[7:4]));
    if (eff(0)) begin mem[wr_addr[3:0]] = wr_data[31:0]; busy[wr_addr[3:0]] = 0; end
    if (eff(1)) begin mem[wr_addr[7:4]] = wr_data[63:32]; busy[wr_addr[7:4]] = 0; end
    if (iss_en && !prot(iss_addr)) busy[iss_addr] = 1;
    m_dbg = mem[dbg_addr];
  endfunction

  task automatic cyc();
    push_exp();
    commit();
    @(posedge clk);
    #2;
  endtask

  task automatic mid_reset();
    #1 reset = 1;
    model_reset();
    cyc();
    reset = 0;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rd_data_byp", rd_data_b, e.bd);
        chk("rd_data_nobyp", rd_data_n, e.nd);
        chk("rd_busy_byp", 64'(rd_busy_b), 64'(e.bb));
        chk("rd_busy_nobyp", 64'(rd_busy_n), 64'(e.nb));
        chk("dbg_byp", 64'(dbg_b), 64'(e.dbg));
        chk("dbg_nobyp", 64'(dbg_n), 64'(e.dbg));
        chk("wr_err_byp", 64'(err_b), 64'(e.err));
        chk("wr_err_nobyp", 64'(err_n), 64'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    @(posedge clk);
    #2;
    reset = 0;
    rd_addr = {4'd13, 4'd5};
    cyc();
    wr_en = 2'b01; wr_addr = 8'h03; wr_data = {32'h0, 32'hDEAD_BEEF}; rd_addr = 8'h03;
    cyc();
    wr_en = 2'b00;
    cyc();
    wr_en = 2'b11; wr_addr = 8'h77; wr_data = {32'd2, 32'd1}; dbg_addr = 4'd7; rd_addr = 8'h77;
    cyc();
    wr_en = 2'b00;
    cyc();
    wr_en = 2'b01; wr_addr = 8'h0E; wr_data = 64'd9; rd_addr = 8'hE0; dbg_addr = 4'd14;
    cyc();
    wr_en = 2'b00;
    cyc();
    cyc();
    iss_en = 1; iss_addr = 4'd4; rd_addr = 8'h04;
    cyc();
    cyc();
    wr_en = 2'b01; wr_addr = 8'h04; wr_data = 64'h55;
    cyc();
    iss_en = 0; wr_en = 2'b00;
    cyc();
    wr_en = 2'b01; wr_data = 64'h66;
    cyc();
    wr_en = 2'b00;
    cyc();
    iss_en = 1; iss_addr = 4'd9;
    cyc();
    wr_en = 2'b11; wr_addr = 8'h93; iss_en = 1; iss_addr = 4'd2; rd_addr = 8'h92;
    mid_reset();
    wr_en = 2'b00; iss_en = 0;
    cyc();
    for (int n = 0; n < 400; n++) begin
      wr_en = 2'($urandom);
      wr_addr = 8'($urandom);
      wr_data = {$urandom, $urandom};
      iss_en = ($urandom_range(0, 2) == 0);
      iss_addr = 4'($urandom);
      dbg_addr = 4'($urandom);
      rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 8'($urandom);
      if ($urandom_range(0, 60) == 0) mid_reset();
      else cyc();
    end
    wr_en = 2'b00; iss_en = 0;
    cyc();
    @(negedge clk);
    #1;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
